// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves a branch in ID using operands forwarded from
// EX/MEM/WB (priority EX > MEM > WB > regfile). A load in EX or MEM that feeds
// a branch operand holds the branch in WAIT with stall_o asserted until the
// operand becomes forwardable.
// Optional feature: define BRANCH_RESOLVE_STATS_EN to add saturating 16-bit
// counters of taken branches (taken_cnt_o) and stall cycles (stall_cnt_o).
//
// Handshake: br_valid_i is a level held by ID for as long as the branch sits
// there. The unit answers with a single-cycle resolved_o pulse; taken_o and
// fwd_*_o are meaningful while resolved_o is high. stall_o is combinational
// and asks the pipeline to hold IF/ID and bubble EX in the current cycle.
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid_i,
  input  logic [2:0]        br_op_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic              ex_wr_en_i,
  input  logic [REG_AW-1:0] ex_wr_addr_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wr_en_i,
  input  logic [REG_AW-1:0] mem_wr_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_is_load_i,
  input  logic              wb_wr_en_i,
  input  logic [REG_AW-1:0] wb_wr_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              stall_o,
  output logic              resolved_o,
  output logic              taken_o,
  output logic [1:0]        fwd_rs_o,
  output logic [1:0]        fwd_rt_o,
  output logic [1:0]        state_dbg_o
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [15:0]       taken_cnt_o,
  output logic [15:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SRC_RF  = 2'd0;
  localparam logic [1:0] SRC_WB  = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_EX  = 2'd3;

  state_t            r_state;
  logic              r_resolved;
  logic              r_taken;
  logic [1:0]        r_fwd_rs;
  logic [1:0]        r_fwd_rt;

  logic [1:0]        w_rs_sel;
  logic [1:0]        w_rt_sel;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_hazard;
  logic              w_taken;
  logic              w_stall;

  // Forwarding source select; register 0 never forwards.
  always_comb begin
    w_rs_sel = SRC_RF;
    if (rs_addr_i != '0) begin
      if (ex_wr_en_i && (ex_wr_addr_i == rs_addr_i))        w_rs_sel = SRC_EX;
      else if (mem_wr_en_i && (mem_wr_addr_i == rs_addr_i)) w_rs_sel = SRC_MEM;
      else if (wb_wr_en_i && (wb_wr_addr_i == rs_addr_i))   w_rs_sel = SRC_WB;
    end
    w_rt_sel = SRC_RF;
    if (rt_addr_i != '0) begin
      if (ex_wr_en_i && (ex_wr_addr_i == rt_addr_i))        w_rt_sel = SRC_EX;
      else if (mem_wr_en_i && (mem_wr_addr_i == rt_addr_i)) w_rt_sel = SRC_MEM;
      else if (wb_wr_en_i && (wb_wr_addr_i == rt_addr_i))   w_rt_sel = SRC_WB;
    end
  end

  // Operand data mux following the selected source.
  always_comb begin
    w_rs_val = rs_data_i;
    case (w_rs_sel)
      SRC_EX:  w_rs_val = ex_data_i;
      SRC_MEM: w_rs_val = mem_data_i;
      SRC_WB:  w_rs_val = wb_data_i;
      default: w_rs_val = rs_data_i;
    endcase
    w_rt_val = rt_data_i;
    case (w_rt_sel)
      SRC_EX:  w_rt_val = ex_data_i;
      SRC_MEM: w_rt_val = mem_data_i;
      SRC_WB:  w_rt_val = wb_data_i;
      default: w_rt_val = rt_data_i;
    endcase
  end

  // Load-use hazard: the chosen producer has not got its data yet.
  always_comb begin
    w_hazard = ((w_rs_sel == SRC_EX)  && ex_is_load_i)  ||
               ((w_rs_sel == SRC_MEM) && mem_is_load_i) ||
               ((w_rt_sel == SRC_EX)  && ex_is_load_i)  ||
               ((w_rt_sel == SRC_MEM) && mem_is_load_i);
  end

  // Branch condition; sign tests use the operand MSB as the DATA_W-bit sign.
  always_comb begin
    w_taken = 1'b0;
    case (br_op_i)
      3'd0:    w_taken = (w_rs_val == w_rt_val);
      3'd1:    w_taken = (w_rs_val != w_rt_val);
      3'd2:    w_taken = w_rs_val[DATA_W-1] || (w_rs_val == '0);
      3'd3:    w_taken = !w_rs_val[DATA_W-1] && (w_rs_val != '0);
      3'd4:    w_taken = w_rs_val[DATA_W-1];
      3'd5:    w_taken = !w_rs_val[DATA_W-1];
      default: w_taken = 1'b0;
    endcase
  end

  // Stall only while a live branch in IDLE/WAIT sees a hazard; reset kills it at once.
  always_comb begin
    w_stall = !rst && br_valid_i && w_hazard && (r_state != S_DONE);
  end

  // Resolution FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_resolved <= 1'b0;
      r_taken    <= 1'b0;
      r_fwd_rs   <= SRC_RF;
      r_fwd_rt   <= SRC_RF;
    end else begin
      r_resolved <= 1'b0;
      case (r_state)
        S_IDLE, S_WAIT: begin
          if (!br_valid_i) begin
            r_state <= S_IDLE;
          end else if (w_hazard) begin
            r_state <= S_WAIT;
          end else begin
            r_state    <= S_DONE;
            r_resolved <= 1'b1;
            r_taken    <= w_taken;
            r_fwd_rs   <= w_rs_sel;
            r_fwd_rt   <= w_rt_sel;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] r_taken_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_resolve_now;

  always_comb begin
    w_resolve_now = br_valid_i && !w_hazard && (r_state != S_DONE);
  end

  // Saturating counters of taken resolutions and stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_resolve_now && w_taken && (r_taken_cnt != 16'hFFFF))
        r_taken_cnt <= r_taken_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign taken_cnt_o = r_taken_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

  assign stall_o     = w_stall;
  assign resolved_o  = r_resolved;
  assign taken_o     = r_taken;
  assign fwd_rs_o    = r_fwd_rs;
  assign fwd_rt_o    = r_fwd_rt;
  assign state_dbg_o = r_state;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vectors, expected results are
// queued by the driver and popped by a monitor on every resolved_o pulse.
module tb_branch_resolve_unit;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              br_valid_i = 0;
  logic [2:0]        br_op_i = 0;
  logic [REG_AW-1:0] rs_addr_i = 0, rt_addr_i = 0;
  logic [DATA_W-1:0] rs_data_i = 0, rt_data_i = 0;
  logic              ex_wr_en_i = 0, ex_is_load_i = 0;
  logic [REG_AW-1:0] ex_wr_addr_i = 0;
  logic [DATA_W-1:0] ex_data_i = 0;
  logic              mem_wr_en_i = 0, mem_is_load_i = 0;
  logic [REG_AW-1:0] mem_wr_addr_i = 0;
  logic [DATA_W-1:0] mem_data_i = 0;
  logic              wb_wr_en_i = 0;
  logic [REG_AW-1:0] wb_wr_addr_i = 0;
  logic [DATA_W-1:0] wb_data_i = 0;
  logic              stall_o, resolved_o, taken_o;
  logic [1:0]        fwd_rs_o, fwd_rt_o, state_dbg_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0]       taken_cnt_o, stall_cnt_o;
`endif

  branch_resolve_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .br_valid_i(br_valid_i), .br_op_i(br_op_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .ex_wr_en_i(ex_wr_en_i), .ex_wr_addr_i(ex_wr_addr_i),
    .ex_data_i(ex_data_i), .ex_is_load_i(ex_is_load_i),
    .mem_wr_en_i(mem_wr_en_i), .mem_wr_addr_i(mem_wr_addr_i),
    .mem_data_i(mem_data_i), .mem_is_load_i(mem_is_load_i),
    .wb_wr_en_i(wb_wr_en_i), .wb_wr_addr_i(wb_wr_addr_i), .wb_data_i(wb_data_i),
    .stall_o(stall_o), .resolved_o(resolved_o), .taken_o(taken_o),
    .fwd_rs_o(fwd_rs_o), .fwd_rt_o(fwd_rt_o), .state_dbg_o(state_dbg_o)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .taken_cnt_o(taken_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];   // {taken, fwd_rs, fwd_rt}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every resolved_o pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && resolved_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resolved", 32'd1, 32'd0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("resolve_result", {27'd0, taken_o, fwd_rs_o, fwd_rt_o}, {27'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stages();
    ex_wr_en_i = 0; ex_wr_addr_i = 0; ex_data_i = 0; ex_is_load_i = 0;
    mem_wr_en_i = 0; mem_wr_addr_i = 0; mem_data_i = 0; mem_is_load_i = 0;
    wb_wr_en_i = 0; wb_wr_addr_i = 0; wb_data_i = 0;
  endtask

  task automatic set_br(input logic [2:0] op, input logic [REG_AW-1:0] rsa,
                        input logic [REG_AW-1:0] rta, input logic [DATA_W-1:0] rsd,
                        input logic [DATA_W-1:0] rtd);
    br_valid_i = 1; br_op_i = op;
    rs_addr_i = rsa; rt_addr_i = rta; rs_data_i = rsd; rt_data_i = rtd;
  endtask

  // Hazard-free branch: no stall, resolved_o one cycle later. Stages set by caller.
  task automatic simple_br(input string name, input logic [2:0] op,
                           input logic [REG_AW-1:0] rsa, input logic [REG_AW-1:0] rta,
                           input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                           input logic [4:0] exp);
    set_br(op, rsa, rta, rsd, rtd);
    exp_q.push_back(exp);
    @(negedge clk);
    chk({name, "_nostall"}, {31'd0, stall_o}, 32'd0);
    tick();
    br_valid_i = 0;
    @(negedge clk);
    chk({name, "_latency"}, {31'd0, resolved_o}, 32'd1);
    clear_stages();
    tick();
  endtask

  // Load-use branch on r2: in_ex=1 starts with the load in EX (2 stalls),
  // otherwise in MEM (1 stall).
  task automatic load_br(input string name, input bit in_ex);
    if (in_ex) begin
      ex_wr_en_i = 1; ex_wr_addr_i = 5'd2; ex_is_load_i = 1; ex_data_i = 32'hDEAD;
      exp_q.push_back({1'b1, 2'd2, 2'd0});
    end else begin
      mem_wr_en_i = 1; mem_wr_addr_i = 5'd2; mem_is_load_i = 1; mem_data_i = 32'hDEAD;
      exp_q.push_back({1'b1, 2'd1, 2'd0});
    end
    set_br(3'd0, 5'd2, 5'd4, 32'd99, 32'd4);
    @(negedge clk);
    chk({name, "_stall1"}, {31'd0, stall_o}, 32'd1);
    tick();
    if (in_ex) begin
      clear_stages();
      mem_wr_en_i = 1; mem_wr_addr_i = 5'd2; mem_is_load_i = 1; mem_data_i = 32'hDEAD;
      @(negedge clk);
      chk({name, "_stall2"}, {31'd0, stall_o}, 32'd1);
      tick();
      mem_is_load_i = 0; mem_data_i = 32'd4;
    end else begin
      clear_stages();
      wb_wr_en_i = 1; wb_wr_addr_i = 5'd2; wb_data_i = 32'd4;
    end
    @(negedge clk);
    chk({name, "_stall_end"}, {31'd0, stall_o}, 32'd0);
    tick();
    br_valid_i = 0;
    @(negedge clk);
    chk({name, "_resolved"}, {31'd0, resolved_o}, 32'd1);
    clear_stages();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_stages();
    rst = 1;
    set_br(3'd0, 5'd2, 5'd0, 0, 0);
    ex_wr_en_i = 1; ex_wr_addr_i = 5'd2; ex_is_load_i = 1;   // would stall if not in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_resolved", {31'd0, resolved_o}, 32'd0);
    chk("rst_taken", {31'd0, taken_o}, 32'd0);
    chk("rst_fwd", {28'd0, fwd_rs_o, fwd_rt_o}, 32'd0);
    chk("rst_state", {30'd0, state_dbg_o}, 32'd0);
    br_valid_i = 0; clear_stages();
    @(posedge clk); #1;
    rst = 0;

    // First branch accepted on the first edge after reset release.
    simple_br("beq_rf", 3'd0, 5'd3, 5'd4, 32'd5, 32'd5, {1'b1, 2'd0, 2'd0});

    tick();
    ex_wr_en_i = 1; ex_wr_addr_i = 5'd3; ex_data_i = 32'd7;
    simple_br("bne_ex", 3'd1, 5'd3, 5'd4, 32'd5, 32'd5, {1'b1, 2'd3, 2'd0});

    tick();
    wb_wr_en_i = 1; wb_wr_addr_i = 5'd5; wb_data_i = 32'd9;
    mem_wr_en_i = 1; mem_wr_addr_i = 5'd6; mem_data_i = 32'd9;
    ex_wr_en_i = 1; ex_wr_addr_i = 5'd7; ex_data_i = 32'd1;
    simple_br("beq_wb_mem", 3'd0, 5'd5, 5'd6, 32'd0, 32'd3, {1'b1, 2'd1, 2'd2});

    tick();
    ex_wr_en_i = 1; ex_wr_addr_i = 5'd8; ex_data_i = 32'd1;
    mem_wr_en_i = 1; mem_wr_addr_i = 5'd8; mem_data_i = 32'd2;
    wb_wr_en_i = 1; wb_wr_addr_i = 5'd8; wb_data_i = 32'd3;
    simple_br("priority_ex", 3'd0, 5'd8, 5'd9, 32'd4, 32'd1, {1'b1, 2'd3, 2'd0});

    tick();
    ex_wr_en_i = 0; ex_wr_addr_i = 5'd8; ex_data_i = 32'd1;   // disabled EX ignored
    mem_wr_en_i = 1; mem_wr_addr_i = 5'd8; mem_data_i = 32'd2;
    simple_br("wren_off", 3'd1, 5'd8, 5'd9, 32'd1, 32'd1, {1'b1, 2'd2, 2'd0});

    tick();
    ex_wr_en_i = 1; ex_wr_addr_i = 5'd0; ex_data_i = 32'hFFFFFFFF;
    simple_br("bgez_r0", 3'd5, 5'd0, 5'd0, 32'd0, 32'd0, {1'b1, 2'd0, 2'd0});

    tick();
    simple_br("bltz_min", 3'd4, 5'd9, 5'd0, 32'h80000000, 32'd0, {1'b1, 2'd0, 2'd0});
    tick();
    simple_br("blez_zero", 3'd2, 5'd9, 5'd0, 32'd0, 32'd0, {1'b1, 2'd0, 2'd0});
    tick();
    simple_br("bgtz_zero", 3'd3, 5'd9, 5'd0, 32'd0, 32'd0, {1'b0, 2'd0, 2'd0});
    tick();
    simple_br("bgtz_max", 3'd3, 5'd9, 5'd0, 32'h7FFFFFFF, 32'd0, {1'b1, 2'd0, 2'd0});
    tick();
    simple_br("blez_neg", 3'd2, 5'd9, 5'd0, 32'hFFFFFFFF, 32'd0, {1'b1, 2'd0, 2'd0});
    tick();
    simple_br("bltz_pos", 3'd4, 5'd9, 5'd0, 32'd1, 32'd0, {1'b0, 2'd0, 2'd0});
    tick();
    simple_br("op6", 3'd6, 5'd3, 5'd4, 32'd5, 32'd5, {1'b0, 2'd0, 2'd0});
    tick();
    simple_br("op7", 3'd7, 5'd3, 5'd4, 32'd5, 32'd5, {1'b0, 2'd0, 2'd0});

    tick();
    load_br("ex_load", 1'b1);
    tick();
    load_br("mem_load", 1'b0);

    // Branch withdrawn while stalled: no resolution.
    tick();
    ex_wr_en_i = 1; ex_wr_addr_i = 5'd2; ex_is_load_i = 1;
    set_br(3'd0, 5'd2, 5'd0, 0, 0);
    tick();
    chk("drop_wait_state", {30'd0, state_dbg_o}, 32'd1);
    br_valid_i = 0;
    #1;
    chk("drop_stall", {31'd0, stall_o}, 32'd0);
    tick();
    @(negedge clk);
    chk("drop_no_resolve", {31'd0, resolved_o}, 32'd0);
    chk("drop_idle", {30'd0, state_dbg_o}, 32'd0);
    clear_stages();
    tick();

    // Reset in the middle of WAIT.
    ex_wr_en_i = 1; ex_wr_addr_i = 5'd2; ex_is_load_i = 1;
    set_br(3'd0, 5'd2, 5'd0, 0, 0);
    tick();
    @(negedge clk);
    chk("rstwait_stall_pre", {31'd0, stall_o}, 32'd1);
    #2 rst = 1;
    #1;
    chk("rstwait_stall", {31'd0, stall_o}, 32'd0);
    chk("rstwait_state", {30'd0, state_dbg_o}, 32'd0);
    tick();
    rst = 0; br_valid_i = 0; clear_stages();
    repeat (3) begin
      @(negedge clk);
      chk("rstwait_no_resolve", {31'd0, resolved_o}, 32'd0);
    end
    tick();

    // br_valid held high through DONE: one idle cycle between resolutions.
    exp_q.push_back({1'b1, 2'd0, 2'd0});
    exp_q.push_back({1'b1, 2'd0, 2'd0});
    set_br(3'd0, 5'd3, 5'd4, 32'd1, 32'd1);
    tick();
    @(negedge clk);
    chk("gap_first", {31'd0, resolved_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("gap_idle", {31'd0, resolved_o}, 32'd0);
    tick();
    br_valid_i = 0;
    @(negedge clk);
    chk("gap_second", {31'd0, resolved_o}, 32'd1);
    tick();

`ifdef BRANCH_RESOLVE_STATS_EN
    @(negedge clk) rst = 1;
    tick();
    rst = 0;
    chk("stats_clear", {taken_cnt_o, stall_cnt_o}, 32'd0);
    simple_br("st_t1", 3'd0, 5'd3, 5'd4, 32'd5, 32'd5, {1'b1, 2'd0, 2'd0});
    tick();
    simple_br("st_nt", 3'd1, 5'd3, 5'd4, 32'd5, 32'd5, {1'b0, 2'd0, 2'd0});
    tick();
    simple_br("st_t2", 3'd5, 5'd3, 5'd4, 32'd5, 32'd5, {1'b1, 2'd0, 2'd0});
    tick();
    load_br("st_load", 1'b1);
    @(negedge clk);
    chk("stats_taken_cnt", {16'd0, taken_cnt_o}, 32'd3);
    chk("stats_stall_cnt", {16'd0, stall_cnt_o}, 32'd2);
`endif

    repeat (2) tick();
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the bench always ends on its own.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand width in bits.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have ports br_valid_i (input, 1, branch present in ID) and br_op_i (input, 3, compare mode).
REQ-006 SHALL have ports rs_addr_i and rt_addr_i (input, REG_AW, ID source addresses).
REQ-007 SHALL have ports rs_data_i and rt_data_i (input, DATA_W, register-file read data).
REQ-008 SHALL have, for each stage S in {ex, mem, wb}: S_wr_en_i (input, 1), S_wr_addr_i (input, REG_AW) and S_data_i (input, DATA_W); ex and mem SHALL also have S_is_load_i (input, 1).
REQ-009 SHALL have port stall_o, output, 1, meaning hold IF/ID and bubble EX.
REQ-010 SHALL have ports resolved_o (output, 1, one-cycle pulse) and taken_o (output, 1, valid while resolved_o is high).
REQ-011 SHALL have ports fwd_rs_o and fwd_rt_o (output, 2; 0 = regfile, 1 = WB, 2 = MEM, 3 = EX), meaning the registered source selection used for the last compare.

Function
REQ-012 SHALL treat a stage as a match for operand X when its wr_en is 1, its wr_addr equals X's address, and X's address is nonzero; register 0 SHALL always use regfile data.
REQ-013 SHALL select the matching stage with priority EX > MEM > WB > regfile, independently for rs and rt.
REQ-014 SHALL flag a hazard when the selected stage is EX with ex_is_load_i = 1, or the selected stage is MEM with mem_is_load_i = 1.
REQ-015 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-016 In IDLE with br_valid_i = 1: on hazard, SHALL go to WAIT with stall_o = 1 (combinational); on no hazard, SHALL go to DONE.
REQ-017 In WAIT, SHALL re-evaluate every cycle; stall_o SHALL stay 1 while the hazard persists, and the FSM SHALL go to DONE in the first hazard-free cycle.
REQ-018 A load in EX SHALL therefore produce exactly 2 stall cycles, and a load in MEM exactly 1.
REQ-019 On entry to DONE, SHALL register taken_o and fwd_*_o from the hazard-free cycle's operands; resolved_o SHALL be 1 for exactly one cycle in DONE; the FSM SHALL then go to IDLE.
REQ-020 br_op_i SHALL decode as: 0 BEQ rs==rt; 1 BNE rs!=rt; 2 BLEZ rs<=0; 3 BGTZ rs>0; 4 BLTZ rs<0; 5 BGEZ rs>=0 (codes 2-5 signed, DATA_W-bit); 6 and 7 SHALL give taken_o = 0 with resolved_o still pulsing.
REQ-021 If br_valid_i falls while in WAIT, SHALL return to IDLE, deassert stall_o, and produce no resolved_o pulse.
REQ-022 If br_valid_i is high in DONE, SHALL treat it as a new branch only after returning to IDLE (one-cycle gap minimum).
REQ-023 Resolution latency SHALL be 1 cycle from a hazard-free br_valid_i to resolved_o.

Reset
REQ-024 rst = 1 SHALL immediately force IDLE, with stall_o = 0, resolved_o = 0, taken_o = 0, fwd_rs_o = 0 and fwd_rt_o = 0, including mid-WAIT.
REQ-025 After rst falls, SHALL accept a branch on the first rising edge.

Configuration
REQ-026 When macro BRANCH_RESOLVE_STATS_EN is defined, SHALL add outputs taken_cnt_o and stall_cnt_o (16 bits each), counting resolved-taken branches and stall cycles, saturating at 0xFFFF and cleared by rst.
REQ-027 When BRANCH_RESOLVE_STATS_EN is undefined, those ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-028 BEQ, rs = r3 = 5, rt = r4 = 5, no matches -> resolved_o pulse after 1 cycle, taken_o = 1, fwd = 0/0.
REQ-029 BNE, rs = r3, EX writes r3 = 7 (non-load), regfile r3 = 5, rt = 5 -> taken_o = 1, fwd_rs_o = 3.
REQ-030 BEQ, rs = r2 matches an EX load -> stall_o high for 2 cycles, then resolved_o, with fwd_rs_o = 2 using MEM data.
REQ-031 BGEZ, rs = r0, EX writes r0 = 0xFFFFFFFF -> no forward, taken_o = 1; BLTZ with rs = 0x80000000 -> taken_o = 1.
REQ-032 rst asserted in the middle of WAIT -> stall_o = 0 immediately, and no resolved_o pulse after release.
REQ-033 With BRANCH_RESOLVE_STATS_EN, 3 taken branches plus 1 load stall -> taken_cnt_o = 3, stall_cnt_o = 2.
